convolve_image_seq: RTL and testbench

Clocked, parametrised successor to the combinational convolve_image. It computes a valid-mode (no padding, stride 1) 2-D convolution of an N x N signed fixed-point image with a K x K filter. Both operands are read through synchronous-read memory ports, and the engine uses one shared MAC. Results are streamed out in raster order with per-result address, fixed-point saturation and optional ReLU.

---
 rtl/convolve_image_seq_if.sv | 30 +++
 rtl/convolve_image_seq.sv | 121 ++++++++++++
 tb/tb_convolve_image_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/convolve_image_seq_if.sv
// convolve_image_seq_if: control, memory-port and result-stream bundle for convolve_image_seq
interface convolve_image_seq_if #(
  parameter int N = 10,
  parameter int K = 5,
  parameter int W = 16
);
  localparam int M   = N - K + 1;
  localparam int IAW = N * N > 1 ? $clog2(N * N) : 1;
  localparam int FAW = K * K > 1 ? $clog2(K * K) : 1;
  localparam int OAW = M * M > 1 ? $clog2(M * M) : 1;
  logic           start;
  logic           relu_en;
  logic           busy;
  logic           done;
  logic [IAW-1:0] img_addr;
  logic [W-1:0]   img_data;
  logic [FAW-1:0] flt_addr;
  logic [W-1:0]   flt_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [OAW-1:0] out_addr;
  modport master (
    output start, relu_en, img_data, flt_data,
    input  busy, done, img_addr, flt_addr, out_valid, out_data, out_addr
  );
  modport slave (
    input  start, relu_en, img_data, flt_data,
    output busy, done, img_addr, flt_addr, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/convolve_image_seq.sv
// convolve_image_seq: valid-mode KxK convolution over an NxN image with one shared MAC and saturating output
module convolve_image_seq #(
  parameter int N    = 10,
  parameter int K    = 5,
  parameter int W    = 16,
  parameter int FRAC = 10
) (
  input logic                clk,
  input logic                rst,
  convolve_image_seq_if.slave bus
);
  localparam int M   = N - K + 1;
  localparam int AW  = 2 * W + $clog2(K * K);
  localparam int IAW = N * N > 1 ? $clog2(N * N) : 1;
  localparam int FAW = K * K > 1 ? $clog2(K * K) : 1;
  localparam int OAW = M * M > 1 ? $clog2(M * M) : 1;
  localparam int CW  = $clog2(N + 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, ISSUE, LAST, EMIT, DONE} state_t;
  state_t                 state_q;
  logic [CW-1:0]          r_q, c_q, i_q, j_q, nr, nc, ni, nj, ar, ac, ai, aj;
  logic                   relu_q, busy_q, done_q, out_valid_q;
  logic [W-1:0]           out_data_q, sat, res;
  logic [OAW-1:0]         out_addr_q, out_addr_nx;
  logic [IAW-1:0]         img_addr_q, img_nx;
  logic [FAW-1:0]         flt_addr_q, flt_nx;
  logic signed [AW-1:0]   acc_q, prod_x, s;
  logic signed [2*W-1:0]  prod;
  logic                   i_last, j_last, r_last, c_last;
  always_comb begin
    j_last = j_q == CW'(K - 1);
    i_last = i_q == CW'(K - 1);
    c_last = c_q == CW'(M - 1);
    r_last = r_q == CW'(M - 1);
    nj = j_last ? '0 : j_q + 1'b1;
    ni = j_last ? i_q + 1'b1 : i_q;
    nc = c_last ? '0 : c_q + 1'b1;
    nr = c_last ? r_q + 1'b1 : r_q;
    // Address targets: next tap in ISSUE, first tap of the next window in EMIT, origin on accept
    ar = state_q == EMIT ? nr : state_q == ISSUE ? r_q : '0;
    ac = state_q == EMIT ? nc : state_q == ISSUE ? c_q : '0;
    ai = state_q == ISSUE ? ni : '0;
    aj = state_q == ISSUE ? nj : '0;
    img_nx = IAW'((32'(ar) + 32'(ai)) * N + 32'(ac) + 32'(aj));
    flt_nx = FAW'(32'(ai) * K + 32'(aj));
    out_addr_nx = OAW'(32'(r_q) * M + 32'(c_q));
    prod = (2*W)'($signed(bus.img_data)) * (2*W)'($signed(bus.flt_data));
    prod_x = AW'(prod);
    s = acc_q >>> FRAC;
    sat = s > SMAX ? {1'b0, {(W-1){1'b1}}} : s < SMIN ? {1'b1, {(W-1){1'b0}}} : s[W-1:0];
    res = relu_q && sat[W-1] ? '0 : sat;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      {r_q, c_q, i_q, j_q} <= '0;
      {relu_q, busy_q, done_q, out_valid_q} <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      img_addr_q <= '0;
      flt_addr_q <= '0;
      acc_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          relu_q <= bus.relu_en;
          {r_q, c_q, i_q, j_q} <= '0;
          img_addr_q <= img_nx;
          flt_addr_q <= flt_nx;
          busy_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          acc_q <= (i_q == '0 && j_q == '0) ? '0 : acc_q + prod_x;
          if (i_last && j_last) state_q <= LAST;
          else begin
            i_q <= ni;
            j_q <= nj;
            img_addr_q <= img_nx;
            flt_addr_q <= flt_nx;
          end
        end
        LAST: begin
          acc_q <= acc_q + prod_x;
          state_q <= EMIT;
        end
        EMIT: begin
          out_valid_q <= 1'b1;
          out_data_q <= res;
          out_addr_q <= out_addr_nx;
          r_q <= nr;
          c_q <= nc;
          if (r_last && c_last) state_q <= DONE;
          else begin
            i_q <= '0;
            j_q <= '0;
            img_addr_q <= img_nx;
            flt_addr_q <= flt_nx;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.img_addr  = img_addr_q;
  assign bus.flt_addr  = flt_addr_q;
endmodule

// File: tb/tb_convolve_image_seq.sv
// tb_convolve_image_seq: scoreboard bench with a direct-arithmetic convolution model and random stimulus
module tb_convolve_image_seq;
  localparam int N = 10, K = 5, W = 16, FRAC = 10, M = N - K + 1;
  typedef struct { int a; longint d; } exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int strobes = 0, first_cyc = 0, last_cyc = 0, acc_cyc = 0, done_cyc = 0;
  logic signed [W-1:0] img [N*N];
  logic signed [W-1:0] flt [K*K];
  exp_t expq[$];
  convolve_image_seq_if #(.N(N), .K(K), .W(W)) bus ();
  convolve_image_seq #(.N(N), .K(K), .W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.img_data <= img[bus.img_addr];
    bus.flt_data <= flt[bus.flt_addr];
  end
  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk) if (!rst && bus.out_valid) begin
    exp_t e;
    if (strobes == 0) first_cyc = cyc;
    last_cyc = cyc;
    strobes++;
    if (expq.size() == 0) chk("unexpected_strobe", 1, 0);
    else begin
      e = expq.pop_front();
      chk("out_addr", longint'(bus.out_addr), e.a);
      chk("out_data", longint'($signed(bus.out_data)), e.d);
    end
  end
  task automatic model(bit relu);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        longint sum = 0, v;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            sum += longint'(img[(r + i) * N + c + j]) * longint'(flt[i * K + j]);
        v = sum >>> FRAC;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (relu && v < 0) v = 0;
        expq.push_back('{r * M + c, v});
      end
  endtask
  task automatic fill(int iv, int fv);
    foreach (img[k]) img[k] = W'(iv);
    foreach (flt[k]) flt[k] = W'(fv);
  endtask
  task automatic run(bit relu, bit extra);
    model(relu);
    strobes = 0;
    @(negedge clk);
    bus.start = 1;
    bus.relu_en = relu;
    @(negedge clk);
    bus.start = 0;
    bus.relu_en = 0;
    acc_cyc = cyc;
    chk("busy_after_accept", bus.busy, 1);
    for (int t = 0; t < 1100; t++) begin
      @(negedge clk);
      if (bus.done) break;
      bus.start = extra && (t % 50 == 7);
      bus.relu_en = ~relu;
    end
    bus.start = 0;
    bus.relu_en = 0;
    done_cyc = cyc;
    chk("done_seen", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("strobe_count", strobes, M * M);
    chk("first_latency", first_cyc - acc_cyc, K * K + 2);
    chk("last_latency", last_cyc - acc_cyc, M * M * (K * K + 2));
    chk("done_after_last", done_cyc - last_cyc, 1);
    chk("queue_drained", expq.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask
  initial begin
    bus.start = 0;
    bus.relu_en = 0;
    fill(1024, 512);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_img_addr", bus.img_addr, 0);
    chk("rst_flt_addr", bus.flt_addr, 0);
    rst = 0;
    run(0, 0);
    chk("half_scale_value", $signed(bus.out_data), 12800);
    fill(1024, 2048);
    run(0, 0);
    chk("pos_saturation", $signed(bus.out_data), 32767);
    fill(1024, 1024);
    img[3] = -16'sd24576;
    run(0, 0);
    img[3] = -16'sd30720;
    run(0, 0);
    run(1, 0);
    fill(-1024, 2048);
    run(0, 0);
    chk("neg_saturation", $signed(bus.out_data), -32768);
    run(1, 0);
    chk("relu_zero", $signed(bus.out_data), 0);
    fill(1024, 512);
    model(0);
    strobes = 0;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (99) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_done", bus.done, 0);
    expq.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    strobes = 0;
    repeat (60) @(negedge clk);
    chk("no_strobe_after_abort", strobes, 0);
    chk("no_busy_after_abort", bus.busy, 0);
    run(0, 1);
    fill(1, 1);
    run(0, 0);
    chk("small_truncate", $signed(bus.out_data), 0);
    fill(-1, 1);
    run(0, 0);
    chk("small_floor", $signed(bus.out_data), -1);
    for (int n = 0; n < 4; n++) begin
      foreach (img[k]) img[k] = W'($urandom);
      foreach (flt[k]) flt[k] = W'($urandom_range(0, 4095) - 2048);
      run(1'($urandom_range(0, 1)), n[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
